// File: rtl/brick_redraw_engine.sv
// -----------------------------------------------------------------------------
// brick_redraw_engine
//
// Collects brick-collision updates from NCH sources, queues them in a small
// FIFO and rasterises each queued brick as a BRICK_W x BRICK_H rectangle on the
// VGA pixel-write port, with a colour derived from the brick's new health.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   col_valid    per-channel request valid
//   col_x        per-channel brick top-left x, channel i at [10i+9:10i]
//   col_y        per-channel brick top-left y, same packing
//   col_health   per-channel new health, channel i at [2i+1:2i]
//   col_ready    one-hot grant (combinational), transfer on valid & ready
//   writeEn      pixel write strobe (high for every DRAW cycle)
//   x_out,y_out  pixel coordinate (wraps modulo 1024, no clipping)
//   color        pixel colour, latched per brick
//   busy         engine is not idle
//   brick_done   one-cycle pulse in the cycle after a brick's last pixel
//   fifo_count   current FIFO occupancy
// -----------------------------------------------------------------------------
module brick_redraw_engine #(
    parameter int NCH        = 2,
    parameter int DEPTH      = 4,
    parameter int BRICK_W    = 32,
    parameter int BRICK_H    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           col_valid,
    input  logic [10*NCH-1:0]        col_x,
    input  logic [10*NCH-1:0]        col_y,
    input  logic [2*NCH-1:0]         col_health,
    output logic [NCH-1:0]           col_ready,
    output logic                     writeEn,
    output logic [9:0]               x_out,
    output logic [9:0]               y_out,
    output logic [2:0]               color,
    output logic                     busy,
    output logic                     brick_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int IW  = (NCH > 1)        ? $clog2(NCH)        : 1;
    localparam int CXW = (BRICK_W > 1)    ? $clog2(BRICK_W)    : 1;
    localparam int CYW = (BRICK_H > 1)    ? $clog2(BRICK_H)    : 1;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CXW-1:0] CX_LAST  = CXW'(BRICK_W - 1);
    localparam logic [CYW-1:0] CY_LAST  = CYW'(BRICK_H - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, GAP} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] health;
    } entry_t;

    // Health to colour: 0 erases the brick, 1..3 are the damage shades.
    function automatic logic [2:0] colour_of(input logic [1:0] health);
        case (health)
            2'd0:    colour_of = 3'b000;
            2'd1:    colour_of = 3'b111;
            2'd2:    colour_of = 3'b101;
            default: colour_of = 3'b011;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [AW:0]      count_q;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [IW-1:0]    rr_q, grant_idx;
    logic             full, push, pop;
    entry_t           in_entry, head_q;
    entry_t           mem [DEPTH];

    logic [9:0]       x0;
    logic [CXW-1:0]   cx_q;
    logic [CYW-1:0]   cy_q;
    logic [GW-1:0]    gap_q;
    logic             last_px, gap_last;

    // ------------------------------------------------------------------
    // Round-robin arbiter. Full comes from the registered count, so a pop
    // in the same cycle never opens a slot early.
    // ------------------------------------------------------------------
    assign full = (count_q == (AW+1)'(DEPTH));

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        col_ready = '0;
        grant_idx = '0;
        push      = 1'b0;
        if (!reset && !full) begin
            // Walk from the farthest candidate to the nearest so the nearest
            // valid channel at or after rr_q is the last (winning) write.
            for (int k = NCH - 1; k >= 0; k--) begin
                if (col_valid[(int'(rr_q) + k) % NCH]) begin
                    grant_idx = IW'((int'(rr_q) + k) % NCH);
                    push      = 1'b1;
                end
            end
            if (push) col_ready = NCH'(1) << grant_idx;
        end
    end

    assign in_entry = {col_x[10*int'(grant_idx) +: 10],
                       col_y[10*int'(grant_idx) +: 10],
                       col_health[2*int'(grant_idx) +: 2]};

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    assign pop = (state_q == IDLE) && (count_q != '0);

    // NOTE: the storage array and the popped-entry register carry no reset;
    // validity is tracked entirely by the pointers and count, which do reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
        if (pop)  head_q      <= mem[rd_ptr];
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            rr_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_q   <= (grant_idx == IW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Draw FSM
    // ------------------------------------------------------------------
    assign last_px  = (cx_q == CX_LAST) && (cy_q == CY_LAST);
    assign gap_last = (gap_q == GAP_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = LOAD;
            LOAD:    state_d = DRAW;
            DRAW:    if (last_px) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel coordinates are registered one step ahead: LOAD presents the
    // first pixel, each DRAW edge presents the next one, and after the last
    // pixel nothing changes so the outputs hold outside DRAW.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0         <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            gap_q      <= '0;
            x_out      <= '0;
            y_out      <= '0;
            color      <= '0;
            brick_done <= 1'b0;
        end else begin
            brick_done <= (state_q == DRAW) && last_px;
            case (state_q)
                LOAD: begin
                    x0    <= head_q.x;
                    color <= colour_of(head_q.health);
                    cx_q  <= '0;
                    cy_q  <= '0;
                    gap_q <= '0;
                    x_out <= head_q.x;
                    y_out <= head_q.y;
                end
                DRAW: begin
                    if (!last_px) begin
                        if (cx_q == CX_LAST) begin
                            cx_q  <= '0;
                            cy_q  <= cy_q + 1'b1;
                            x_out <= x0;
                            y_out <= y_out + 1'b1;
                        end else begin
                            cx_q  <= cx_q + 1'b1;
                            x_out <= x_out + 1'b1;
                        end
                    end
                end
                GAP:     gap_q <= gap_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign writeEn    = (state_q == DRAW);
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_brick_redraw_engine.sv
// -----------------------------------------------------------------------------
// Bench for brick_redraw_engine. Sources are modelled as per-channel request
// queues that hold valid until granted. The reference model predicts, cycle by
// cycle, the grant vector, FIFO occupancy and a per-brick schedule of expected
// output records (pop, load, pixels, gap) built from the brick geometry.
// -----------------------------------------------------------------------------
module tb_brick_redraw_engine;

    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int BW    = 32;
    localparam int BH    = 8;
    localparam int GAP   = 2;

    logic                   clk   = 1'b0;
    logic                   reset = 1'b1;
    logic [NCH-1:0]         col_valid  = '0;
    logic [10*NCH-1:0]      col_x      = '0;
    logic [10*NCH-1:0]      col_y      = '0;
    logic [2*NCH-1:0]       col_health = '0;
    logic [NCH-1:0]         col_ready;
    logic                   writeEn;
    logic [9:0]             x_out, y_out;
    logic [2:0]             color;
    logic                   busy, brick_done;
    logic [$clog2(DEPTH):0] fifo_count;

    brick_redraw_engine #(
        .NCH(NCH), .DEPTH(DEPTH), .BRICK_W(BW), .BRICK_H(BH), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .col_valid(col_valid), .col_x(col_x), .col_y(col_y), .col_health(col_health),
        .col_ready(col_ready), .writeEn(writeEn), .x_out(x_out), .y_out(y_out),
        .color(color), .busy(busy), .brick_done(brick_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int h; } req_t;
    typedef struct { bit busy; bit we; int x; int y; int c; bit done; } exp_t;

    req_t chq [NCH][$];
    bit   consumed [NCH];
    req_t fifo_m [$];
    exp_t sched [$];
    int   rr_m;
    int   last_x, last_y, last_c;

    int   n_checks, n_fail;
    int   we_cnt, done_cnt, max_cnt;
    int   pix_x [$], pix_y [$], pix_c [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int colour_of(input int h);
        case (h)
            0:       return 0;
            1:       return 7;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    // Expected output records for the cycles following a pop.
    task automatic build(input req_t b);
        sched.push_back('{1, 0, 0, 0, 0, 0});                       // LOAD
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                sched.push_back('{1, 1, (b.x + c) % 1024, (b.y + r) % 1024, colour_of(b.h), 0});
        for (int g = 0; g < GAP; g++)
            sched.push_back('{1, 0, 0, 0, 0, (g == 0)});
    endtask

    // Monitor, driver and reference model, all stepping on the falling edge.
    initial begin
        exp_t rec;
        req_t b;
        int   g;
        bit   idle_now;
        logic [NCH-1:0] exp_ready;
        rr_m = 0; last_x = 0; last_y = 0; last_c = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (consumed[i]) begin
                    if (chq[i].size() > 0) void'(chq[i].pop_front());
                    consumed[i] = 1'b0;
                end
                if (chq[i].size() > 0) begin
                    col_valid[i]            = 1'b1;
                    col_x[i*10 +: 10]       = 10'(chq[i][0].x);
                    col_y[i*10 +: 10]       = 10'(chq[i][0].y);
                    col_health[i*2 +: 2]    = 2'(chq[i][0].h);
                end else begin
                    col_valid[i]            = 1'b0;
                    col_x[i*10 +: 10]       = 10'($urandom);
                    col_y[i*10 +: 10]       = 10'($urandom);
                    col_health[i*2 +: 2]    = 2'($urandom);
                end
            end
            #1;

            idle_now = (sched.size() == 0);
            rec = idle_now ? '{0, 0, 0, 0, 0, 0} : sched.pop_front();
            if (rec.we) begin
                last_x = rec.x; last_y = rec.y; last_c = rec.c;
            end
            check("busy", busy, rec.busy);
            check("writeEn", writeEn, rec.we);
            check("brick_done", brick_done, rec.done);
            check("x_out", x_out, last_x);
            check("y_out", y_out, last_y);
            check("color", color, last_c);
            check("fifo_count", fifo_count, fifo_m.size());

            g = -1;
            if (!reset && fifo_m.size() < DEPTH)
                for (int k = 0; k < NCH; k++)
                    if (g < 0 && col_valid[(rr_m + k) % NCH]) g = (rr_m + k) % NCH;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("col_ready", col_ready, exp_ready);

            if (writeEn === 1'b1) begin
                we_cnt++;
                pix_x.push_back(int'(x_out));
                pix_y.push_back(int'(y_out));
                pix_c.push_back(int'(color));
            end
            if (brick_done === 1'b1) done_cnt++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);

            // Advance the model across the coming rising edge.
            if (reset) begin
                fifo_m.delete();
                sched.delete();
                rr_m = 0; last_x = 0; last_y = 0; last_c = 0;
            end else begin
                if (idle_now && fifo_m.size() > 0) begin
                    b = fifo_m.pop_front();
                    build(b);
                end
                if (g >= 0) begin
                    fifo_m.push_back(chq[g][0]);
                    rr_m = (g + 1) % NCH;
                    consumed[g] = 1'b1;
                end
            end
        end
    end

    function automatic bit pending();
        bit p = (fifo_m.size() > 0) || (sched.size() > 0);
        for (int i = 0; i < NCH; i++) if (chq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, (n < budget), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            chq[i].delete();
            consumed[i] = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic clear_log();
        pix_x.delete(); pix_y.delete(); pix_c.delete();
    endtask

    initial begin
        int base_we, base_done, n;
        req_t r;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single brick from channel 0
        clear_log();
        base_we = we_cnt; base_done = done_cnt;
        chq[0].push_back('{100, 40, 2});
        wait_drained("t1_drain", 2000);
        check("t1_pixels", we_cnt - base_we, 256);
        check("t1_done", done_cnt - base_done, 1);
        check("t1_first_x", pix_x[0], 100);
        check("t1_first_y", pix_y[0], 40);
        check("t1_last_x", pix_x[255], 131);
        check("t1_last_y", pix_y[255], 47);
        check("t1_color", pix_c[0], 5);
        check("t1_busy", busy, 0);

        // Both channels at once after reset: ch0 first, then ch1, then ch0 again
        do_reset();
        clear_log();
        chq[0].push_back('{10, 10, 1});
        chq[1].push_back('{500, 300, 3});
        wait_drained("t2_drain", 2000);
        check("t2_order0", pix_x[0], 10);
        check("t2_order1", pix_x[256], 500);
        clear_log();
        chq[0].push_back('{20, 20, 1});
        chq[1].push_back('{600, 200, 2});
        wait_drained("t2b_drain", 2000);
        check("t2_again0", pix_x[0], 20);
        check("t2_again1", pix_x[256], 600);

        // Fill the FIFO, then hold ch1 valid against a full queue
        clear_log();
        max_cnt = 0;
        for (int i = 0; i < 5; i++) chq[0].push_back('{40 * i, 8 * i, i % 4});
        repeat (20) @(posedge clk);
        chq[1].push_back('{900, 900, 1});
        wait_drained("t3_drain", 4000);
        check("t3_full_reached", max_cnt, DEPTH);
        check("t3_ch1_last", pix_x[5*256], 900);

        // Erase colour with wrap on both axes
        clear_log();
        chq[0].push_back('{1020, 1020, 0});
        wait_drained("t4_drain", 2000);
        check("t4_color", pix_c[0], 0);
        check("t4_x_wrap", pix_x[4], 0);
        check("t4_x_row_end", pix_x[31], 27);
        check("t4_y_wrap", pix_y[255], 3);

        // Randomised traffic
        for (int i = 0; i < 16; i++) begin
            r.x = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
            r.y = $urandom_range(0, 1023);
            r.h = $urandom_range(0, 3);
            chq[$urandom_range(0, NCH - 1)].push_back(r);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 400)) @(posedge clk);
        end
        wait_drained("t5_drain", 12000);

        // Reset mid-draw with two bricks queued
        clear_log();
        base_we = we_cnt;
        chq[0].push_back('{200, 100, 1});
        chq[1].push_back('{300, 150, 2});
        chq[0].push_back('{400, 200, 3});
        n = 0;
        while (we_cnt - base_we < 50 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("t6_reach_px50", (n < 1000), 1);
        do_reset();
        base_we = we_cnt; base_done = done_cnt;
        repeat (300) @(posedge clk);
        check("t6_no_pixels", we_cnt - base_we, 0);
        check("t6_no_done", done_cnt - base_done, 0);
        check("t6_fifo_empty", fifo_count, 0);
        check("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
